// File: rtl/arbitro_registrador_if.sv
// Bundle of requester handshake and external register signals shared by the arbiter.
// The slave modport is the arbiter's view; master is the requester/register environment.
interface arbitro_registrador_if #(
    parameter int N = 4,
    parameter int W = 16
);
    logic [N-1:0]   req;
    logic [N-1:0]   we;
    logic [N*W-1:0] dados;
    logic [N-1:0]   ack;
    logic [W-1:0]   leitura;
    logic           ocupado;
    logic           reg_load;
    logic [W-1:0]   reg_d;
    logic [W-1:0]   reg_q;

    modport master (
        output req, we, dados, reg_q,
        input  ack, leitura, ocupado, reg_load, reg_d
    );

    modport slave (
        input  req, we, dados, reg_q,
        output ack, leitura, ocupado, reg_load, reg_d
    );
endinterface

// File: rtl/arbitro_registrador.sv
// Round-robin arbiter sequencing N four-phase req/ack requesters onto one external register.
// Each grant runs IDLE -> one ACCESS cycle -> CONFIRM (ack held until req drops).
module arbitro_registrador #(
    parameter int N = 4,
    parameter int W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    arbitro_registrador_if.slave   bus
);
    localparam int PW = $clog2(N);

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        ACESSO   = 2'd1,
        CONFIRMA = 2'd2
    } estado_t;

    estado_t       r_state;
    estado_t       w_next;
    logic [PW-1:0] r_ptr;
    logic [PW-1:0] r_grant;
    logic          r_we;
    logic [W-1:0]  r_dados;
    logic [W-1:0]  r_leitura;
    logic [PW-1:0] w_winner;
    logic          w_any;
    logic [W-1:0]  w_dados_sel;

    // Scan from ptr upward with wraparound; iterating offsets high-to-low lets the nearest one win.
    always_comb begin
        logic [PW:0] sum;
        sum      = '0;
        w_any    = 1'b0;
        w_winner = '0;
        for (int k = N - 1; k >= 0; k--) begin
            sum = {1'b0, r_ptr} + (PW+1)'(k);
            if (sum >= (PW+1)'(N)) begin
                sum = sum - (PW+1)'(N);
            end
            if (bus.req[sum[PW-1:0]]) begin
                w_any    = 1'b1;
                w_winner = sum[PW-1:0];
            end
        end
    end

    always_comb begin
        w_dados_sel = bus.dados[w_winner*W +: W];
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= OCIOSO;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            OCIOSO:   if (w_any) w_next = ACESSO;
            ACESSO:   w_next = CONFIRMA;
            CONFIRMA: if (!bus.req[r_grant]) w_next = OCIOSO;
            default:  w_next = OCIOSO;
        endcase
    end

    // Grant latch, pointer and read capture. r_dados only follows writes so reg_d
    // keeps presenting the last write value while idle or during reads.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr     <= '0;
            r_grant   <= '0;
            r_we      <= 1'b0;
            r_dados   <= '0;
            r_leitura <= '0;
        end else begin
            case (r_state)
                OCIOSO: begin
                    if (w_any) begin
                        r_grant <= w_winner;
                        r_we    <= bus.we[w_winner];
                        if (bus.we[w_winner]) begin
                            r_dados <= w_dados_sel;
                        end
                    end
                end
                ACESSO: begin
                    if (!r_we) begin
                        r_leitura <= bus.reg_q;
                    end
                    r_ptr <= (r_grant == PW'(N - 1)) ? '0 : r_grant + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Outputs decode registered state only; reset masks load so an in-flight write is dropped.
    always_comb begin
        bus.reg_load = 1'b0;
        bus.ocupado  = 1'b0;
        case (r_state)
            ACESSO: begin
                bus.reg_load = r_we & ~reset;
                bus.ocupado  = 1'b1;
            end
            CONFIRMA: bus.ocupado = 1'b1;
            default: ;
        endcase
    end

    assign bus.reg_d   = r_dados;
    assign bus.leitura = r_leitura;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_ack
            assign bus.ack[gi] = (r_state == CONFIRMA) && (r_grant == PW'(gi));
        end
    endgenerate
endmodule
